session_rcv: RTL and testbench
==============================

Name: session_rcv

Overview:
- Session-layer receive stage directly downstream of the transport receive block.
- Consumes the transport's typed 16-bit word strobe (control or audio) and decodes control words into a call-state machine plus a one-cycle command event.
- Buffers audio words in an internal FIFO that the codec playback path drains at sample rate.
- Drives sessionBusy back to the transport stage to throttle it.

Parameters:
- AUDIO_DEPTH, 64, audio FIFO depth in 16-bit words; power of two, 8..1024.
- BUSY_MARGIN, 8, sessionBusy asserts when FIFO occupancy >= AUDIO_DEPTH-BUSY_MARGIN; must be >= 4 to absorb in-flight transport words.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- sendingToSession  in  2  word type strobe: 2'b01 control word, 2'b10 audio word, 2'b00 none, 2'b11 illegal. Valid for exactly one cycle per word.
- data  in  16  word payload, sampled when sendingToSession!=0.
- sessionBusy  out  1  registered backpressure to the transport stage.
- audio_rd_en  in  1  playback pop request.
- audio_out  out  16  popped sample.
- audio_valid  out  1  one-cycle pulse; audio_out is valid while it is high.
- audio_empty  out  1  FIFO occupancy == 0, combinational from the count register.
- ctrl_valid  out  1  one-cycle pulse per accepted control word.
- ctrl_cmd  out  8  data[15:8] of the last control word.
- ctrl_arg  out  8  data[7:0] of the last control word.
- call_state  out  2  current call FSM state.
- caller_id  out  8  arg latched on RING.
- err_flags  out  3  sticky flags: [0] overflow, [1] underflow, [2] bad word (type 11 or unknown cmd). Cleared only by reset.

Behaviour:
- Reset values: every output 0, call_state IDLE, FIFO pointers and count 0, audio_empty 1.
- Control path:
  - type 01 at edge N → ctrl_cmd/ctrl_arg updated and ctrl_valid=1 during cycle N+1.
  - The FSM transition takes effect on the same edge N.
- Command codes: RING=8'h01, ACCEPT=8'h02, HANGUP=8'h03, REJECT=8'h04. Any other code still pulses ctrl_valid, sets err[2], and causes no state change.
- Call FSM encoding: IDLE=0, RINGING=1, CONNECTED=2, CLOSING=3.
- FSM transitions:
  - IDLE + RING → RINGING; latch caller_id=arg.
  - RINGING + ACCEPT → CONNECTED.
  - RINGING + REJECT → CLOSING.
  - Any state + HANGUP → CLOSING.
  - CLOSING → IDLE unconditionally after one cycle; the FIFO is flushed (pointers and count cleared) on that edge.
  - A valid command arriving in a state with no defined transition for it is ignored (no error flag).
- Audio write:
  - Type 10 is written only when call_state==CONNECTED and count<AUDIO_DEPTH.
  - Audio outside CONNECTED is silently dropped (no flag).
  - Audio while full is dropped and sets err[0].
  - The full check uses the pre-edge count: a simultaneous pop does not make room for that edge's write.
- Audio read:
  - audio_rd_en with count>0 at edge N → audio_out = head word and audio_valid=1 during cycle N+1.
  - audio_rd_en while empty sets err[1]; audio_valid stays 0 and audio_out holds its last value.
- Count and pointers:
  - Simultaneous accepted write and read leaves count unchanged.
  - Pointers are log2(AUDIO_DEPTH) bits and wrap naturally; count is log2(AUDIO_DEPTH)+1 bits.
- sessionBusy: registered from the post-edge count, so it lags occupancy by one cycle. Also forced to 1 while call_state==CLOSING.
- Type 11: ignored; sets err[2].
- Reset mid-operation: reset has priority over all events in the same cycle. Pending words in flight are lost; no pulse outputs fire on the cycle after reset.

Decomposition:
- Package session_pkg holds:
  - word type codes (TYPE_CTRL=2'b01, TYPE_AUDIO=2'b10);
  - command codes;
  - call-state encodings;
  - err bit indices.
- One sub-module, session_audio_fifo, parameterised by AUDIO_DEPTH:
  - inputs wr_en/din, rd_en, flush;
  - outputs dout, dout_valid, count, and overflow/underflow pulses.
- The FSM, control decoding and sticky flags stay in session_rcv.

Test Plan:
- Call setup: RING arg 8'h2A, then ACCEPT → call_state 0→1→2; caller_id=8'h2A; two ctrl_valid pulses with ctrl_cmd 01 then 02.
- Audio in CONNECTED: push 5 words 16'h1000..16'h1004, then pop 5 → audio_out in order, each with a one-cycle audio_valid; audio_empty returns to 1; err_flags=0.
- Fill and overflow (DEPTH=64, MARGIN=8): push 56 → sessionBusy=1 one cycle after the 56th write. Push 70 total → count=64, err[0]=1, words 65..70 absent on readout.
- Underflow and simultaneous access: pop with FIFO empty → err[1]=1, no audio_valid. At count=64, write plus pop on the same edge → write dropped, count=63.
- Teardown: HANGUP with 10 words buffered → CLOSING for one cycle with sessionBusy=1, then IDLE with audio_empty=1. An audio word sent during IDLE is not stored.
- Errors and reset: cmd 8'h7F → ctrl_valid pulses, state unchanged, err[2]=1. Type 11 → err[2]=1. reset=0 for one edge mid-traffic → all outputs 0, IDLE, count 0.

Source files
------------

// File: rtl/session_pkg.sv
// Shared word-type, command, call-state and error-bit definitions for the
// session receive stage.
package session_pkg;

   localparam logic [1:0] TYPE_NONE  = 2'b00;
   localparam logic [1:0] TYPE_CTRL  = 2'b01;
   localparam logic [1:0] TYPE_AUDIO = 2'b10;
   localparam logic [1:0] TYPE_BAD   = 2'b11;

   localparam logic [7:0] CMD_RING   = 8'h01;
   localparam logic [7:0] CMD_ACCEPT = 8'h02;
   localparam logic [7:0] CMD_HANGUP = 8'h03;
   localparam logic [7:0] CMD_REJECT = 8'h04;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RINGING   = 2'd1,
      ST_CONNECTED = 2'd2,
      ST_CLOSING   = 2'd3
   } call_state_t;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;
   localparam int ERR_BAD = 2;

   function automatic logic cmd_known(input logic [7:0] cmd);
      return (cmd == CMD_RING) || (cmd == CMD_ACCEPT) ||
             (cmd == CMD_HANGUP) || (cmd == CMD_REJECT);
   endfunction

endpackage

// File: rtl/session_rcv_if.sv
// Transport-to-session word strobe with the backpressure return path.
interface session_rcv_if;
   logic [1:0]  sendingToSession;
   logic [15:0] data;
   logic        sessionBusy;

   modport master (output sendingToSession, output data, input sessionBusy);
   modport slave  (input sendingToSession, input data, output sessionBusy);
endinterface

// File: rtl/session_audio_fifo.sv
// Audio sample FIFO: registered pop data, flush clears pointers and count,
// overflow/underflow are same-cycle pulses for the parent's sticky flags.
module session_audio_fifo #(
   parameter int AUDIO_DEPTH = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_en,
   input  logic [15:0]                    din,
   input  logic                           rd_en,
   input  logic                           flush,
   output logic [15:0]                    dout,
   output logic                           dout_valid,
   output logic [$clog2(AUDIO_DEPTH):0]   count,
   output logic                           overflow,
   output logic                           underflow
);
   localparam int AW = $clog2(AUDIO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(AUDIO_DEPTH);

   logic [15:0]   mem [AUDIO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          wr_ok;
   logic          rd_ok;

   // Full/empty decisions use the pre-edge count, so a pop never frees a slot
   // for a write on the same edge.
   assign wr_ok     = wr_en && (count < FULL_CNT) && !flush;
   assign rd_ok     = rd_en && (count != '0) && !flush;
   assign overflow  = wr_en && (count == FULL_CNT) && !flush;
   assign underflow = rd_en && (count == '0) && !flush;

   always_ff @(posedge clk) begin
      if (reset && wr_ok) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (flush) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= rd_ok;
         if (wr_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_ok) begin
            dout <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/session_rcv.sv
// Session receive stage: control-word decode into the call FSM, audio
// buffering toward playback, sticky error flags and transport backpressure.
//
//   state     | meaning
//   IDLE      | no call; waiting for RING
//   RINGING   | incoming call announced, caller_id latched
//   CONNECTED | call up, audio words are buffered
//   CLOSING   | one-cycle teardown; FIFO flushed on exit
module session_rcv
   import session_pkg::*;
#(
   parameter int AUDIO_DEPTH = 64,
   parameter int BUSY_MARGIN = 8
) (
   input  logic               clk,
   input  logic               reset,
   session_rcv_if.slave       tp,
   input  logic               audio_rd_en,
   output logic [15:0]        audio_out,
   output logic               audio_valid,
   output logic               audio_empty,
   output logic               ctrl_valid,
   output logic [7:0]         ctrl_cmd,
   output logic [7:0]         ctrl_arg,
   output logic [1:0]         call_state,
   output logic [7:0]         caller_id,
   output logic [2:0]         err_flags
);
   localparam int AW = $clog2(AUDIO_DEPTH);
   localparam logic [AW:0] BUSY_TH = (AW+1)'(AUDIO_DEPTH - BUSY_MARGIN);

   call_state_t state_q;
   call_state_t state_d;
   logic        is_ctrl;
   logic [7:0]  cmd;
   logic [7:0]  arg;
   logic        fifo_wr;
   logic        fifo_flush;
   logic        latch_caller;
   logic        busy_force;
   logic [AW:0] fifo_count;
   logic        fifo_ovf;
   logic        fifo_udf;
   logic        bad_word;
   logic        busy_q;

   assign is_ctrl  = (tp.sendingToSession == TYPE_CTRL);
   assign cmd      = tp.data[15:8];
   assign arg      = tp.data[7:0];
   assign bad_word = (tp.sendingToSession == TYPE_BAD) || (is_ctrl && !cmd_known(cmd));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // CLOSING always exits to IDLE; HANGUP is honoured from every other state.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_CLOSING) begin
         state_d = ST_IDLE;
      end else if (is_ctrl) begin
         if (cmd == CMD_HANGUP) begin
            state_d = ST_CLOSING;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cmd == CMD_RING) state_d = ST_RINGING;
               end
               ST_RINGING: begin
                  if (cmd == CMD_ACCEPT)      state_d = ST_CONNECTED;
                  else if (cmd == CMD_REJECT) state_d = ST_CLOSING;
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_comb begin
      fifo_flush   = (state_q == ST_CLOSING);
      fifo_wr      = (tp.sendingToSession == TYPE_AUDIO) && (state_q == ST_CONNECTED);
      latch_caller = is_ctrl && (cmd == CMD_RING) && (state_q == ST_IDLE);
      busy_force   = (state_d == ST_CLOSING);
   end

   session_audio_fifo #(.AUDIO_DEPTH(AUDIO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (fifo_wr),
      .din        (tp.data),
      .rd_en      (audio_rd_en),
      .flush      (fifo_flush),
      .dout       (audio_out),
      .dout_valid (audio_valid),
      .count      (fifo_count),
      .overflow   (fifo_ovf),
      .underflow  (fifo_udf)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_valid <= 1'b0;
         ctrl_cmd   <= '0;
         ctrl_arg   <= '0;
         caller_id  <= '0;
         err_flags  <= '0;
         busy_q     <= 1'b0;
      end else begin
         ctrl_valid <= is_ctrl;
         if (is_ctrl) begin
            ctrl_cmd <= cmd;
            ctrl_arg <= arg;
         end
         if (latch_caller) begin
            caller_id <= arg;
         end
         if (fifo_ovf) err_flags[ERR_OVF] <= 1'b1;
         if (fifo_udf) err_flags[ERR_UDF] <= 1'b1;
         if (bad_word) err_flags[ERR_BAD] <= 1'b1;
         // Built from the count register, so it trails occupancy by a cycle.
         busy_q <= (fifo_count >= BUSY_TH) || busy_force;
      end
   end

   assign tp.sessionBusy = busy_q;
   assign audio_empty    = (fifo_count == '0);
   assign call_state     = state_q;

endmodule

// File: tb/tb_session_rcv.sv
// Random and directed stimulus for session_rcv, checked every cycle against a
// queue-based call/FIFO model plus literal spot checks.
module tb_session_rcv;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] audio_out;
   logic        audio_valid;
   logic        audio_empty;
   logic        ctrl_valid;
   logic [7:0]  ctrl_cmd;
   logic [7:0]  ctrl_arg;
   logic [1:0]  call_state;
   logic [7:0]  caller_id;
   logic [2:0]  err_flags;

   int total = 0;
   int bad   = 0;

   session_rcv_if tif ();

   session_rcv #(.AUDIO_DEPTH(64), .BUSY_MARGIN(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .tp          (tif),
      .audio_rd_en (rd_en),
      .audio_out   (audio_out),
      .audio_valid (audio_valid),
      .audio_empty (audio_empty),
      .ctrl_valid  (ctrl_valid),
      .ctrl_cmd    (ctrl_cmd),
      .ctrl_arg    (ctrl_arg),
      .call_state  (call_state),
      .caller_id   (caller_id),
      .err_flags   (err_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: call state as an integer, FIFO as a queue.
   logic [15:0] q[$];
   int          st = 0;
   int          m_oc;
   int          m_ns;
   logic [7:0]  m_cmd;
   bit          mdl_ok = 0;
   logic        e_cv, e_av, e_busy;
   logic [7:0]  e_cmd, e_arg, e_cid;
   logic [15:0] e_out;
   logic [2:0]  e_err;

   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         st = 0; e_cv = 0; e_av = 0; e_busy = 0;
         e_cmd = 0; e_arg = 0; e_cid = 0; e_out = 0; e_err = 0;
         mdl_ok = 1;
      end else begin
         m_oc = q.size();
         m_ns = st;
         e_cv = 0;
         e_av = 0;
         if (st == 3) begin
            q.delete();
            m_ns = 0;
         end else begin
            if (rd_en) begin
               if (m_oc > 0) begin e_out = q.pop_front(); e_av = 1; end
               else e_err[1] = 1;
            end
            if (tif.sendingToSession == 2'b10 && st == 2) begin
               if (m_oc < 64) q.push_back(tif.data);
               else e_err[0] = 1;
            end
         end
         if (tif.sendingToSession == 2'b01) begin
            m_cmd = tif.data[15:8];
            e_cv  = 1;
            e_cmd = m_cmd;
            e_arg = tif.data[7:0];
            if (m_cmd < 1 || m_cmd > 4) e_err[2] = 1;
            else if (st != 3) begin
               if (m_cmd == 3) m_ns = 3;
               else if (st == 0 && m_cmd == 1) begin m_ns = 1; e_cid = tif.data[7:0]; end
               else if (st == 1 && m_cmd == 2) m_ns = 2;
               else if (st == 1 && m_cmd == 4) m_ns = 3;
            end
         end
         if (tif.sendingToSession == 2'b11) e_err[2] = 1;
         e_busy = (m_oc >= 56) || (m_ns == 3);
         st = m_ns;
      end
   end

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("call_state", {30'd0, call_state}, st);
         chk("caller_id", {24'd0, caller_id}, {24'd0, e_cid});
         chk("ctrl_valid", {31'd0, ctrl_valid}, {31'd0, e_cv});
         chk("ctrl_word", {16'd0, ctrl_cmd, ctrl_arg}, {16'd0, e_cmd, e_arg});
         chk("audio_valid", {31'd0, audio_valid}, {31'd0, e_av});
         chk("audio_out", {16'd0, audio_out}, {16'd0, e_out});
         chk("audio_empty", {31'd0, audio_empty}, (q.size() == 0) ? 32'd1 : 32'd0);
         chk("sessionBusy", {31'd0, tif.sessionBusy}, {31'd0, e_busy});
         chk("err_flags", {29'd0, err_flags}, {29'd0, e_err});
      end
   end

   task automatic cyc(input logic [1:0] t, input logic [15:0] d, input logic rd);
      tif.sendingToSession = t;
      tif.data = d;
      rd_en = rd;
      @(negedge clk);
      tif.sendingToSession = 2'b00;
      rd_en = 1'b0;
   endtask

   initial begin
      int rd_pct;
      int k;
      tif.sendingToSession = 2'b00;
      tif.data = '0;
      @(negedge clk);
      @(negedge clk);
      chk("lit_reset_empty", {31'd0, audio_empty}, 1);
      chk("lit_reset_state", {30'd0, call_state}, 0);
      reset = 1'b1;
      cyc(2'b00, 16'h0, 0);

      // Call setup
      cyc(2'b01, 16'h012A, 0);
      chk("lit_ring_valid", {31'd0, ctrl_valid}, 1);
      chk("lit_ring_cmd", {24'd0, ctrl_cmd}, 32'h01);
      chk("lit_ring_state", {30'd0, call_state}, 1);
      chk("lit_caller_id", {24'd0, caller_id}, 32'h2A);
      cyc(2'b01, 16'h0200, 0);
      chk("lit_accept_cmd", {24'd0, ctrl_cmd}, 32'h02);
      chk("lit_accept_state", {30'd0, call_state}, 2);

      // Five words in, five out
      for (int i = 0; i < 5; i++) cyc(2'b10, 16'h1000 + 16'(i), 0);
      for (int i = 0; i < 5; i++) begin
         cyc(2'b00, 16'h0, 1);
         chk("lit_pop_valid", {31'd0, audio_valid}, 1);
         chk("lit_pop_data", {16'd0, audio_out}, 32'h1000 + i);
      end
      cyc(2'b00, 16'h0, 0);
      chk("lit_empty_again", {31'd0, audio_empty}, 1);
      chk("lit_no_err", {29'd0, err_flags}, 0);

      // Fill to overflow
      for (int i = 0; i < 70; i++) begin
         cyc(2'b10, 16'h2000 + 16'(i), 0);
         if (i == 55) chk("lit_busy_lag", {31'd0, tif.sessionBusy}, 0);
         if (i == 56) chk("lit_busy_set", {31'd0, tif.sessionBusy}, 1);
         if (i == 63) chk("lit_no_ovf_yet", {29'd0, err_flags}, 0);
      end
      chk("lit_ovf", {29'd0, err_flags}, 1);

      // Write plus pop while full: write dropped, head pops
      cyc(2'b10, 16'hDEAD, 1);
      chk("lit_full_pop", {16'd0, audio_out}, 32'h2000);
      for (int i = 1; i < 64; i++) begin
         cyc(2'b00, 16'h0, 1);
         chk("lit_drain", {16'd0, audio_out}, 32'h2000 + i);
      end
      cyc(2'b00, 16'h0, 1);
      chk("lit_udf_novalid", {31'd0, audio_valid}, 0);
      chk("lit_udf_hold", {16'd0, audio_out}, 32'h203F);
      chk("lit_udf_flag", {29'd0, err_flags}, 3);

      // Teardown with buffered words
      for (int i = 0; i < 10; i++) cyc(2'b10, 16'h3000 + 16'(i), 0);
      cyc(2'b01, 16'h0300, 0);
      chk("lit_closing", {30'd0, call_state}, 3);
      chk("lit_closing_busy", {31'd0, tif.sessionBusy}, 1);
      cyc(2'b00, 16'h0, 0);
      chk("lit_idle", {30'd0, call_state}, 0);
      chk("lit_flushed", {31'd0, audio_empty}, 1);
      cyc(2'b10, 16'h5555, 0);
      cyc(2'b00, 16'h0, 0);
      chk("lit_idle_drop", {31'd0, audio_empty}, 1);

      // Reset mid-traffic, then error words
      cyc(2'b01, 16'h0177, 0);
      reset = 1'b0;
      cyc(2'b10, 16'h4444, 1);
      reset = 1'b1;
      chk("lit_rst_state", {30'd0, call_state}, 0);
      chk("lit_rst_outs", {16'd0, ctrl_cmd, caller_id}, 0);
      chk("lit_rst_pulses", {29'd0, ctrl_valid, audio_valid, tif.sessionBusy}, 0);
      chk("lit_rst_err", {29'd0, err_flags}, 0);
      cyc(2'b11, 16'h0, 0);
      chk("lit_type11", {29'd0, err_flags}, 4);
      cyc(2'b01, 16'h7F00, 0);
      chk("lit_bad_cmd_valid", {31'd0, ctrl_valid}, 1);
      chk("lit_bad_cmd_state", {30'd0, call_state}, 0);

      // Random traffic, checked every cycle by the model
      reset = 1'b0;
      cyc(2'b00, 16'h0, 0);
      reset = 1'b1;
      rd_pct = 40;
      for (int n = 0; n < 4000; n++) begin
         logic [1:0]  t;
         logic [15:0] d;
         if (n % 500 == 0) rd_pct = $urandom_range(20, 80);
         k = $urandom_range(0, 99);
         d = 16'($urandom);
         if (k < 55)      t = 2'b10;
         else if (k < 92) t = 2'b00;
         else if (k < 99) begin
            t = 2'b01;
            case ($urandom_range(0, 9))
               0, 1, 2: d[15:8] = 8'h01;
               3, 4, 5: d[15:8] = 8'h02;
               6:       d[15:8] = 8'h03;
               7:       d[15:8] = 8'h04;
               8:       d[15:8] = 8'h05 + 8'($urandom_range(0, 200));
               default: d[15:8] = 8'h00;
            endcase
         end else t = 2'b11;
         if ($urandom_range(0, 999) == 0) reset = 1'b0;
         cyc(t, d, ($urandom_range(0, 99) < rd_pct) ? 1'b1 : 1'b0);
         reset = 1'b1;
      end
      cyc(2'b00, 16'h0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
